aabb_pair_collider: RTL and testbench

//  Broadphase stage downstream of the per-geom AABB units (sphere/box/capsule). Collects up to MAX_GEOMS

---
 rtl/aabb_pair_collider_pkg.sv | 26 ++
 rtl/aabb_pair_collider_fp32_le.sv | 37 +++
 rtl/aabb_pair_collider.sv | 156 +++++++++++++++
 tb/tb_aabb_pair_collider.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aabb_pair_collider_pkg.sv
// Shared definitions for the AABB broadphase pair collider: float width, AABB field
// layout, FSM state encoding and a NaN helper used by the float comparator.
package aabb_pair_collider_pkg;

    localparam int FP_W     = 32;
    localparam int N_FIELDS = 6;

    localparam int MINX = 0;
    localparam int MAXX = 1;
    localparam int MINY = 2;
    localparam int MAXY = 3;
    localparam int MINZ = 4;
    localparam int MAXZ = 5;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SCAN,
        ST_EMIT,
        ST_DONE
    } state_e;

    function automatic logic fp32_is_nan(input logic [FP_W-1:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/aabb_pair_collider_fp32_le.sv
// Combinational IEEE-754 single-precision a <= b using sign-magnitude ordering.
// Any NaN operand yields false; +0 and -0 compare equal.
module aabb_pair_collider_fp32_le
    import aabb_pair_collider_pkg::*;
(
    input  logic [FP_W-1:0] a_i,
    input  logic [FP_W-1:0] b_i,
    output logic            le_o
);

    logic any_nan;
    logic both_zero;
    logic mag_le;
    logic mag_ge;

    always_comb begin
        any_nan   = fp32_is_nan(a_i) || fp32_is_nan(b_i);
        both_zero = (a_i[30:0] == 31'd0) && (b_i[30:0] == 31'd0);
        mag_le    = a_i[30:0] <= b_i[30:0];
        mag_ge    = a_i[30:0] >= b_i[30:0];
        le_o      = 1'b0;
        if (any_nan) begin
            le_o = 1'b0;
        end else if (both_zero) begin
            le_o = 1'b1;
        end else begin
            // Negative magnitudes order in reverse
            unique case ({a_i[31], b_i[31]})
                2'b00:   le_o = mag_le;
                2'b11:   le_o = mag_ge;
                2'b10:   le_o = 1'b1;
                default: le_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/aabb_pair_collider.sv
// Broadphase: buffers a frame of AABBs, scans every pair i<j one per cycle and streams
// out the overlapping pairs with valid/ready backpressure.
module aabb_pair_collider
    import aabb_pair_collider_pkg::*;
#(
    parameter int MAX_GEOMS = 8,
    parameter int IDX_W     = $clog2(MAX_GEOMS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [FP_W-1:0]  in_aabb0,
    input  logic [FP_W-1:0]  in_aabb1,
    input  logic [FP_W-1:0]  in_aabb2,
    input  logic [FP_W-1:0]  in_aabb3,
    input  logic [FP_W-1:0]  in_aabb4,
    input  logic [FP_W-1:0]  in_aabb5,
    output logic             pair_valid,
    input  logic             pair_ready,
    output logic [IDX_W-1:0] pair_i,
    output logic [IDX_W-1:0] pair_j,
    output logic [15:0]      pair_count,
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W   = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_GEOMS);

    typedef logic [N_FIELDS-1:0][FP_W-1:0] aabb_t;

    state_e           state_q;
    logic [CNT_W-1:0] count_q;
    logic [IDX_W-1:0] i_q;
    logic [IDX_W-1:0] j_q;
    logic [IDX_W-1:0] pair_i_q;
    logic [IDX_W-1:0] pair_j_q;
    logic [15:0]      pair_count_q;
    aabb_t            buf_q [MAX_GEOMS];

    aabb_t            in_box;
    aabb_t            box_a;
    aabb_t            box_b;
    logic [5:0]       le;
    logic             overlap;
    logic             accept;
    logic             j_at_end;
    logic             last_pair;
    logic [IDX_W-1:0] i_d;
    logic [IDX_W-1:0] j_d;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign in_box = {in_aabb5, in_aabb4, in_aabb3, in_aabb2, in_aabb1, in_aabb0};
    assign accept = (state_q == ST_LOAD) && in_valid;

    // Frame buffer holds data only; its contents after reset are irrelevant
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_q[count_q[IDX_W-1:0]] <= in_box;
        end
    end

    assign box_a = buf_q[i_q];
    assign box_b = buf_q[j_q];

    aabb_pair_collider_fp32_le u_le_ax0 (.a_i(box_a[MINX]), .b_i(box_b[MAXX]), .le_o(le[0]));
    aabb_pair_collider_fp32_le u_le_bx0 (.a_i(box_b[MINX]), .b_i(box_a[MAXX]), .le_o(le[1]));
    aabb_pair_collider_fp32_le u_le_ay0 (.a_i(box_a[MINY]), .b_i(box_b[MAXY]), .le_o(le[2]));
    aabb_pair_collider_fp32_le u_le_by0 (.a_i(box_b[MINY]), .b_i(box_a[MAXY]), .le_o(le[3]));
    aabb_pair_collider_fp32_le u_le_az0 (.a_i(box_a[MINZ]), .b_i(box_b[MAXZ]), .le_o(le[4]));
    aabb_pair_collider_fp32_le u_le_bz0 (.a_i(box_b[MINZ]), .b_i(box_a[MAXZ]), .le_o(le[5]));

    assign overlap = &le;

    always_comb begin
        j_at_end  = {1'b0, j_q} == (count_q - CNT_W'(1));
        last_pair = j_at_end && ({1'b0, i_q} == (count_q - CNT_W'(2)));
        i_d       = i_q;
        j_d       = j_q + 1'b1;
        if (j_at_end) begin
            i_d = i_q + 1'b1;
            j_d = i_q + IDX_W'(2);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_LOAD;
            count_q      <= '0;
            i_q          <= '0;
            j_q          <= '0;
            pair_i_q     <= '0;
            pair_j_q     <= '0;
            pair_count_q <= '0;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    if (accept) begin
                        count_q <= count_q + CNT_W'(1);
                        i_q     <= '0;
                        j_q     <= IDX_W'(1);
                        if (count_q == '0) begin
                            pair_count_q <= '0;
                        end
                        // A single-entry frame has no pairs to scan
                        if (in_last || (count_q + CNT_W'(1) == CNT_MAX)) begin
                            state_q <= (count_q == '0) ? ST_DONE : ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    if (overlap) begin
                        state_q  <= ST_EMIT;
                        pair_i_q <= i_q;
                        pair_j_q <= j_q;
                    end else if (last_pair) begin
                        state_q <= ST_DONE;
                    end else begin
                        i_q <= i_d;
                        j_q <= j_d;
                    end
                end
                ST_EMIT: begin
                    if (pair_ready) begin
                        pair_count_q <= sat_inc16(pair_count_q);
                        if (last_pair) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_SCAN;
                            i_q     <= i_d;
                            j_q     <= j_d;
                        end
                    end
                end
                default: begin
                    count_q <= '0;
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    assign in_ready   = (state_q == ST_LOAD);
    assign pair_valid = (state_q == ST_EMIT);
    assign busy       = (state_q == ST_SCAN) || (state_q == ST_EMIT);
    assign done       = (state_q == ST_DONE);
    assign pair_i     = pair_i_q;
    assign pair_j     = pair_j_q;
    assign pair_count = pair_count_q;

endmodule

// File: tb/tb_aabb_pair_collider.sv
// Directed bench for aabb_pair_collider: touching, separated, full buffer with
// backpressure, signed-zero/NaN handling, single-entry frame and async reset mid-emit.
module tb_aabb_pair_collider;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [5:0][31:0] aabb;
    logic             pair_valid;
    logic             pair_ready;
    logic [2:0]       pair_i;
    logic [2:0]       pair_j;
    logic [15:0]      pair_count;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;
    int pq_i[$];
    int pq_j[$];
    int cyc;
    bit got_done;

    localparam logic [31:0] P0   = 32'h00000000;
    localparam logic [31:0] P1   = 32'h3F800000;
    localparam logic [31:0] N1   = 32'hBF800000;
    localparam logic [31:0] P2   = 32'h40000000;
    localparam logic [31:0] PH   = 32'h3F000000;
    localparam logic [31:0] NH   = 32'hBF000000;
    localparam logic [31:0] NZ   = 32'h80000000;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    aabb_pair_collider #(.MAX_GEOMS(8), .IDX_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_aabb0   (aabb[0]),
        .in_aabb1   (aabb[1]),
        .in_aabb2   (aabb[2]),
        .in_aabb3   (aabb[3]),
        .in_aabb4   (aabb[4]),
        .in_aabb5   (aabb[5]),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .pair_i     (pair_i),
        .pair_j     (pair_j),
        .pair_count (pair_count),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0][31:0] box(input logic [31:0] mnx, input logic [31:0] mxx,
                                             input logic [31:0] mny, input logic [31:0] mxy,
                                             input logic [31:0] mnz, input logic [31:0] mxz);
        return {mxz, mnz, mxy, mny, mxx, mnx};
    endfunction

    task automatic send(input logic [5:0][31:0] b, input bit last);
        int w;
        in_valid = 1'b1;
        in_last  = last;
        aabb     = b;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) chk("send_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Runs until done, recording handshaken pairs and checking that stalled pairs hold.
    task automatic collect(input bit rnd);
        logic [2:0] hi;
        logic [2:0] hj;
        bit         hold;
        pq_i.delete();
        pq_j.delete();
        got_done = 1'b0;
        hold     = 1'b0;
        hi       = '0;
        hj       = '0;
        cyc      = 0;
        for (int k = 0; k < 400; k++) begin
            cyc = k;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (hold) begin
                chk("hold_valid", {31'd0, pair_valid}, 32'd1);
                chk("hold_i", {29'd0, pair_i}, {29'd0, hi});
                chk("hold_j", {29'd0, pair_j}, {29'd0, hj});
            end
            pair_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            hold = pair_valid && !pair_ready;
            if (pair_valid && pair_ready) begin
                pq_i.push_back(int'(pair_i));
                pq_j.push_back(int'(pair_j));
            end
            hi = pair_i;
            hj = pair_j;
            tick();
        end
        pair_ready = 1'b0;
        if (!got_done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_pair(input string tag, input int k, input int ei, input int ej);
        if (k < pq_i.size()) begin
            chk({tag, "_i"}, pq_i[k], ei);
            chk({tag, "_j"}, pq_j[k], ej);
        end else begin
            chk({tag, "_missing"}, pq_i.size(), k + 1);
        end
    endtask

    task automatic check_done_pulse(input string tag);
        tick();
        chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int k;
        int w;
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        pair_ready = 1'b0;
        aabb       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_pair_valid", {31'd0, pair_valid}, 32'd0);
        chk("rst_pair_i", {29'd0, pair_i}, 32'd0);
        chk("rst_pair_j", {29'd0, pair_j}, 32'd0);
        chk("rst_pair_count", {16'd0, pair_count}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b1;
        tick();

        // Touching boxes share the face x=1
        send(box(P0, P1, P0, P1, P0, P1), 1'b0);
        send(box(P1, P2, P0, P1, P0, P1), 1'b1);
        chk("touch_busy", {31'd0, busy}, 32'd1);
        collect(1'b0);
        chk("touch_cycles", cyc, 32'd2);
        chk("touch_npairs", pq_i.size(), 32'd1);
        check_pair("touch_p0", 0, 0, 1);
        chk("touch_count", {16'd0, pair_count}, 32'd1);
        check_done_pulse("touch");
        chk("touch_count_hold", {16'd0, pair_count}, 32'd1);

        // Separated along x
        send(box(32'h400ABA5A, 32'h404ABA5A, NH, PH, P1, P2), 1'b0);
        send(box(32'hC1900000, 32'hC1600000, NH, PH, P1, P2), 1'b1);
        collect(1'b0);
        chk("sep_cycles", cyc, 32'd1);
        chk("sep_npairs", pq_i.size(), 32'd0);
        chk("sep_count", {16'd0, pair_count}, 32'd0);
        check_done_pulse("sep");

        // -0.0 max against +0.0 min overlaps
        send(box(N1, NZ, P0, P1, P0, P1), 1'b0);
        send(box(P0, P1, P0, P1, P0, P1), 1'b1);
        collect(1'b0);
        chk("zero_npairs", pq_i.size(), 32'd1);
        check_pair("zero_p0", 0, 0, 1);
        chk("zero_count", {16'd0, pair_count}, 32'd1);
        check_done_pulse("zero");

        // NaN min never overlaps
        send(box(N1, NZ, P0, P1, P0, P1), 1'b0);
        send(box(QNAN, P1, P0, P1, P0, P1), 1'b1);
        collect(1'b0);
        chk("nan_npairs", pq_i.size(), 32'd0);
        chk("nan_count", {16'd0, pair_count}, 32'd0);
        check_done_pulse("nan");

        // Single-entry frame
        send(box(P0, P1, P0, P1, P0, P1), 1'b1);
        chk("one_done", {31'd0, done}, 32'd1);
        chk("one_valid", {31'd0, pair_valid}, 32'd0);
        chk("one_count", {16'd0, pair_count}, 32'd0);
        check_done_pulse("one");

        // Full buffer of identical boxes, random backpressure
        for (int g = 0; g < 8; g++) begin
            send(box(N1, P1, N1, P1, N1, P1), 1'b0);
            if (g == 6) chk("full_ready_7", {31'd0, in_ready}, 32'd1);
        end
        chk("full_ready_drop", {31'd0, in_ready}, 32'd0);
        chk("full_busy", {31'd0, busy}, 32'd1);
        collect(1'b1);
        chk("full_npairs", pq_i.size(), 32'd28);
        k = 0;
        for (int i = 0; i < 7; i++) begin
            for (int j = i + 1; j < 8; j++) begin
                check_pair("full_p", k, i, j);
                k++;
            end
        end
        chk("full_count", {16'd0, pair_count}, 32'd28);
        check_done_pulse("full");
        chk("full_count_hold", {16'd0, pair_count}, 32'd28);

        // Async reset while the second pair of a frame is presented
        send(box(N1, P1, N1, P1, N1, P1), 1'b0);
        chk("rstmid_count_clr", {16'd0, pair_count}, 32'd0);
        send(box(N1, P1, N1, P1, N1, P1), 1'b0);
        send(box(N1, P1, N1, P1, N1, P1), 1'b1);
        pair_ready = 1'b1;
        w = 0;
        while (!pair_valid && w < 20) begin
            tick();
            w++;
        end
        chk("rstmid_first_valid", {31'd0, pair_valid}, 32'd1);
        tick();
        pair_ready = 1'b0;
        w = 0;
        while (!pair_valid && w < 20) begin
            tick();
            w++;
        end
        chk("rstmid_second_valid", {31'd0, pair_valid}, 32'd1);
        chk("rstmid_pair_i", {29'd0, pair_i}, 32'd0);
        chk("rstmid_pair_j", {29'd0, pair_j}, 32'd2);
        chk("rstmid_count1", {16'd0, pair_count}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rstmid_valid", {31'd0, pair_valid}, 32'd0);
        chk("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rstmid_count", {16'd0, pair_count}, 32'd0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("rstmid_after_valid", {31'd0, pair_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
